traffic_light_ctrl_n: RTL and testbench
=======================================

TRAFFIC_LIGHT_CTRL_N -- requirements
Module: traffic_light_ctrl_n

Interface
REQ-001 SHALL have parameter NUM_APPROACH, default 4: approach count, legal range 2..8.
REQ-002 SHALL have parameter GREEN_CYCLES, default 2: green duration in clk cycles, minimum 1.
REQ-003 SHALL have parameter YELLOW_CYCLES, default 1: yellow duration in clk cycles, minimum 1.
REQ-004 SHALL have parameter ALLRED_CYCLES, default 0: all-red clearance duration in clk cycles; 0 means no all-red phase.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port demand, input, NUM_APPROACH bits: per-approach vehicle request, level-sensitive.
REQ-008 SHALL have port emg_req, input, 1 bit: emergency preempt request.
REQ-009 SHALL have port emg_idx, input, IDX_W bits (IDX_W = clog2(NUM_APPROACH)): preempt target approach.
REQ-010 SHALL have port seg, output, 7*NUM_APPROACH bits: seven-segment code per approach; approach i occupies bits [7i+6:7i].
REQ-011 SHALL have port active_idx, output, IDX_W bits: current owning approach.
REQ-012 SHALL have port phase, output, 2 bits: 00 GREEN, 01 YELLOW, 10 ALLRED.
REQ-013 SHALL have port emg_ack, output, 1 bit: high while the preempt target holds green.

Function
REQ-014 SHALL use segment codes R=1110111, Y=0110011, G=1011111; the active approach shows G or Y per phase; all others show R; ALLRED shows R on all approaches.
REQ-015 SHALL be a Moore machine: every output decodes from registered state only, with no combinational input-to-output path.
REQ-016 SHALL implement FSM GREEN -> YELLOW -> ALLRED -> GREEN; ALLRED SHALL be skipped (YELLOW -> GREEN) when ALLRED_CYCLES=0.
REQ-017 SHALL use a down-counter timer: on phase entry it loads the phase duration minus 1, decrements each cycle, and the phase ends on the edge where timer==0, so each phase lasts exactly its parameter in cycles.
REQ-018 SHALL size the timer to clog2(max(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES)+1) bits; the timer never wraps below 0.
REQ-019 SHALL evaluate demand when GREEN reaches timer==0: next approach = first index after active_idx, round-robin with wrap from NUM_APPROACH-1 to 0, whose demand bit is set, excluding active_idx.
REQ-020 SHALL, if no other approach has demand at GREEN expiry, stay in GREEN on the same approach and reload the timer (green extension).
REQ-021 SHALL latch the selected next approach at GREEN exit; demand changes during YELLOW/ALLRED SHALL NOT alter it.
REQ-022 SHALL treat emg_req as valid only when emg_idx < NUM_APPROACH; an invalid emg_idx SHALL be ignored as if emg_req were 0.
REQ-023 SHALL, on valid emg_req during GREEN with active_idx != emg_idx, enter YELLOW on the next edge regardless of timer (green truncation) and latch next = emg_idx.
REQ-024 SHALL, on valid emg_req during YELLOW/ALLRED, complete that phase normally, then enter GREEN on emg_idx (overrides demand choice).
REQ-025 SHALL, while valid emg_req holds and GREEN on emg_idx, hold the timer at GREEN_CYCLES-1 and drive emg_ack=1; after release, normal expiry resumes with a full green period.
REQ-026 SHALL, when emg_idx changes while preempt holds, follow the new target through truncation per REQ-023.

Reset
REQ-027 SHALL, while rst=0 (asynchronous), force phase=GREEN, active_idx=0, timer=GREEN_CYCLES-1, latched next=0, emg_ack=0, seg: approach 0=G, others=R.
REQ-028 SHALL, on reset assertion mid-phase, abandon the phase immediately with no yellow/all-red completion.

Structure
REQ-029 SHALL place segment codes R/Y/G and the phase encoding in shared package traffic_pkg.
REQ-030 SHALL use one sub-module seg_decode (inputs phase, is_active; output 7-bit code), instantiated NUM_APPROACH times via generate.

Verification (NUM_APPROACH=4, GREEN=3, YELLOW=2, ALLRED=1)
REQ-031 SHALL cover: demand=1111 after reset release -> A0 G 3 cycles, Y 2, all R 1, then A1 G; full rotation A0..A3 -> A0 in 24 cycles.
REQ-032 SHALL cover: demand=0100 during A0 green -> after Y/ALLRED, active_idx=2 (A1 skipped); demand=0000 -> A0 stays G indefinitely, phase=00.
REQ-033 SHALL cover: emg_req=1, emg_idx=3 at A0 green cycle 1 -> next edge A0 Y, then ALLRED, then A3 G with emg_ack=1, held 20 cycles; release -> A3 G 3 more cycles.
REQ-034 SHALL cover: emg_req=1, emg_idx=5 -> no effect on sequencing, emg_ack=0.
REQ-035 SHALL cover: rst low during A2 yellow -> same-cycle (no clk edge) A0=G, others R, phase=00, active_idx=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding and seven-segment codes for the traffic light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  localparam logic [6:0] SEG_R = 7'b1110111;
  localparam logic [6:0] SEG_Y = 7'b0110011;
  localparam logic [6:0] SEG_G = 7'b1011111;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Per-approach lamp decode: the owning approach shows green/yellow, everyone else red.
module seg_decode
  import traffic_pkg::*;
(
  input  phase_e     phase,
  input  logic       is_active,
  output logic [6:0] code
);

  always_comb begin
    code = SEG_R;
    if (is_active) begin
      case (phase)
        PH_GREEN:  code = SEG_G;
        PH_YELLOW: code = SEG_Y;
        default:   code = SEG_R;
      endcase
    end
  end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-approach round-robin traffic light sequencer with emergency preempt.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  PH_GREEN  | active approach has right of way; extends if no other demand
//  PH_YELLOW | active approach clearing; next owner already latched
//  PH_ALLRED | every approach red before handing over (skipped if 0 cycles)
module traffic_light_ctrl_n
  import traffic_pkg::*;
#(
  parameter int NUM_APPROACH  = 4,
  parameter int GREEN_CYCLES  = 2,
  parameter int YELLOW_CYCLES = 1,
  parameter int ALLRED_CYCLES = 0,
  localparam int IDX_W = $clog2(NUM_APPROACH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_APPROACH-1:0]   demand,
  input  logic                      emg_req,
  input  logic [IDX_W-1:0]          emg_idx,
  output logic [7*NUM_APPROACH-1:0] seg,
  output logic [IDX_W-1:0]          active_idx,
  output logic [1:0]                phase,
  output logic                      emg_ack
);

  localparam int TW = $clog2(max3(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES) + 1);
  localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_CYCLES - 1);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] T_ALLRED = (ALLRED_CYCLES > 0) ? TW'(ALLRED_CYCLES - 1) : '0;
  localparam logic [IDX_W:0] NUM_LIM = (IDX_W + 1)'(NUM_APPROACH);

  phase_e            phase_q, phase_d;
  logic [IDX_W-1:0]  active_q, active_d;
  logic [IDX_W-1:0]  next_q, next_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              ack_q, ack_d;

  logic              emg_valid;
  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;

  assign emg_valid = emg_req && ({1'b0, emg_idx} < NUM_LIM);

  // Round-robin search starting just after the current owner, never the owner itself.
  always_comb begin
    found = 1'b0;
    pick  = active_q;
    cand  = active_q;
    for (int k = 1; k < NUM_APPROACH; k++) begin
      cand = IDX_W'((int'(active_q) + k) % NUM_APPROACH);
      if (!found && demand[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    next_d   = next_q;
    timer_d  = timer_q;
    case (phase_q)
      PH_GREEN: begin
        if (emg_valid && emg_idx != active_q) begin
          phase_d = PH_YELLOW;
          timer_d = T_YELLOW;
          next_d  = emg_idx;
        end else if (emg_valid) begin
          timer_d = T_GREEN;
        end else if (timer_q == '0) begin
          if (found) begin
            phase_d = PH_YELLOW;
            timer_d = T_YELLOW;
            next_d  = pick;
          end else begin
            timer_d = T_GREEN;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      PH_YELLOW: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (ALLRED_CYCLES > 0) begin
          phase_d = PH_ALLRED;
          timer_d = T_ALLRED;
        end else begin
          phase_d  = PH_GREEN;
          timer_d  = T_GREEN;
          active_d = emg_valid ? emg_idx : next_q;
        end
      end
      PH_ALLRED: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          phase_d  = PH_GREEN;
          timer_d  = T_GREEN;
          active_d = emg_valid ? emg_idx : next_q;
        end
      end
      default: begin
        phase_d = PH_GREEN;
        timer_d = T_GREEN;
      end
    endcase
    // Registered so the acknowledge stays a pure state decode.
    ack_d = emg_valid && (phase_d == PH_GREEN) && (active_d == emg_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_GREEN;
      active_q <= '0;
      next_q   <= '0;
      timer_q  <= T_GREEN;
      ack_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      next_q   <= next_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
    end
  end

  for (genvar i = 0; i < NUM_APPROACH; i++) begin : g_seg
    seg_decode u_dec (
      .phase     (phase_q),
      .is_active (active_q == IDX_W'(i)),
      .code      (seg[7*i +: 7])
    );
  end

  assign active_idx = active_q;
  assign phase      = phase_q;
  assign emg_ack    = ack_q;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed bench: 4-approach controller (G=3, Y=2, AR=1) plus a 5-approach copy for invalid preempt index.
module tb_traffic_light_ctrl_n;

  localparam logic [6:0] R = 7'b1110111;
  localparam logic [6:0] Y = 7'b0110011;
  localparam logic [6:0] G = 7'b1011111;

  logic        clk;
  logic        rst;
  logic [3:0]  demand;
  logic        emg_req;
  logic [1:0]  emg_idx;
  logic [27:0] seg;
  logic [1:0]  active_idx;
  logic [1:0]  phase;
  logic        emg_ack;

  logic [4:0]  demand2;
  logic        emg_req2;
  logic [2:0]  emg_idx2;
  logic [34:0] seg2;
  logic [2:0]  active_idx2;
  logic [1:0]  phase2;
  logic        emg_ack2;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_light_ctrl_n #(
    .NUM_APPROACH(4), .GREEN_CYCLES(3), .YELLOW_CYCLES(2), .ALLRED_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .demand(demand), .emg_req(emg_req), .emg_idx(emg_idx),
    .seg(seg), .active_idx(active_idx), .phase(phase), .emg_ack(emg_ack)
  );

  traffic_light_ctrl_n #(
    .NUM_APPROACH(5), .GREEN_CYCLES(3), .YELLOW_CYCLES(2), .ALLRED_CYCLES(1)
  ) dut5 (
    .clk(clk), .rst(rst), .demand(demand2), .emg_req(emg_req2), .emg_idx(emg_idx2),
    .seg(seg2), .active_idx(active_idx2), .phase(phase2), .emg_ack(emg_ack2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [55:0] exp_seg(input logic [1:0] ph, input int idx, input int n);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (ph == 2'b10 || i != idx) r[7*i +: 7] = R;
      else if (ph == 2'b00)        r[7*i +: 7] = G;
      else                         r[7*i +: 7] = Y;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] ph, input int idx, input logic ack);
    logic [55:0] es;
    es = exp_seg(ph, idx, 4);
    n_assert++;
    assert (phase === ph) else begin
      n_fail++; $error("FAIL %s phase observed=%b expected=%b", tag, phase, ph);
    end
    n_assert++;
    assert (active_idx === 2'(idx)) else begin
      n_fail++; $error("FAIL %s active_idx observed=%0d expected=%0d", tag, active_idx, idx);
    end
    n_assert++;
    assert (emg_ack === ack) else begin
      n_fail++; $error("FAIL %s emg_ack observed=%b expected=%b", tag, emg_ack, ack);
    end
    n_assert++;
    assert (seg === es[27:0]) else begin
      n_fail++; $error("FAIL %s seg observed=%h expected=%h", tag, seg, es[27:0]);
    end
  endtask

  task automatic chk5(input string tag, input logic [1:0] ph, input int idx);
    logic [55:0] es;
    es = exp_seg(ph, idx, 5);
    n_assert++;
    assert (phase2 === ph && active_idx2 === 3'(idx)) else begin
      n_fail++; $error("FAIL %s n5 phase/idx observed=%b/%0d expected=%b/%0d", tag, phase2, active_idx2, ph, idx);
    end
    n_assert++;
    assert (emg_ack2 === 1'b0 && seg2 === es[34:0]) else begin
      n_fail++; $error("FAIL %s n5 ack/seg observed=%b/%h expected=0/%h", tag, emg_ack2, seg2, es[34:0]);
    end
  endtask

  initial begin
    logic [1:0] ph;
    rst = 1'b0; demand = '0; emg_req = 1'b0; emg_idx = '0;
    demand2 = 5'b00010; emg_req2 = 1'b1; emg_idx2 = 3'd5;
    #3;
    chk("reset", 2'b00, 0, 1'b0);
    chk5("reset", 2'b00, 0);

    // Full rotation with all approaches requesting.
    step();
    rst = 1'b1;
    demand = 4'b1111;
    for (int a = 0; a < 4; a++) begin
      for (int c = 0; c < 6; c++) begin
        ph = (c < 3) ? 2'b00 : (c < 5) ? 2'b01 : 2'b10;
        chk($sformatf("rot a%0d c%0d", a, c), ph, a, 1'b0);
        if (a == 0) chk5($sformatf("inv a0 c%0d", c), ph, 0);
        else        chk5($sformatf("inv a%0d c%0d", a, c), 2'b00, 1);
        step();
      end
    end
    chk("rot wrap", 2'b00, 0, 1'b0);

    // Skip to A2; demand change after yellow entry must not move the latched target.
    demand = 4'b0100;
    step(); chk("skip g1", 2'b00, 0, 1'b0);
    step(); chk("skip g2", 2'b00, 0, 1'b0);
    step(); chk("skip y0", 2'b01, 0, 1'b0);
    demand = 4'b1000;
    step(); chk("skip y1", 2'b01, 0, 1'b0);
    step(); chk("skip ar", 2'b10, 0, 1'b0);
    step(); chk("skip a2", 2'b00, 2, 1'b0);

    // Only own demand, then none: green extends.
    demand = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      step(); chk($sformatf("ext own %0d", i), 2'b00, 2, 1'b0);
    end
    demand = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step(); chk($sformatf("ext none %0d", i), 2'b00, 2, 1'b0);
    end

    // Asynchronous reset mid-green.
    #2 rst = 1'b0;
    #1 chk("rst green", 2'b00, 0, 1'b0);
    step();
    rst = 1'b1;

    // Preempt to A3 during A0 green cycle 1.
    demand = 4'b1111; emg_req = 1'b1; emg_idx = 2'd3;
    chk("emg t0", 2'b00, 0, 1'b0);
    step(); chk("emg trunc", 2'b01, 0, 1'b0);
    step(); chk("emg y1", 2'b01, 0, 1'b0);
    step(); chk("emg ar", 2'b10, 0, 1'b0);
    step(); chk("emg a3", 2'b00, 3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(); chk($sformatf("emg hold %0d", i), 2'b00, 3, 1'b1);
    end
    emg_req = 1'b0;
    step(); chk("rel g1", 2'b00, 3, 1'b0);
    step(); chk("rel g2", 2'b00, 3, 1'b0);
    step(); chk("rel y", 2'b01, 3, 1'b0);

    // Preempt arriving during yellow overrides the demand choice (A0).
    emg_req = 1'b1; emg_idx = 2'd2;
    step(); chk("emgy y1", 2'b01, 3, 1'b0);
    step(); chk("emgy ar", 2'b10, 3, 1'b0);
    step(); chk("emgy a2", 2'b00, 2, 1'b1);
    emg_req = 1'b0;
    step(); chk("emgy rel1", 2'b00, 2, 1'b0);
    step(); chk("emgy rel2", 2'b00, 2, 1'b0);
    step(); chk("a2 yellow", 2'b01, 2, 1'b0);

    // Reset during A2 yellow takes effect without a clock edge.
    #2 rst = 1'b0;
    #1 chk("rst yellow", 2'b00, 0, 1'b0);
    step();
    chk("rst held", 2'b00, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
